tiny86_trace_seq: RTL



---
 rtl/tiny86_trace_seq_if.sv | 23 ++
 rtl/tiny86_trace_seq.sv | 134 +++++++++++++
 2 files changed

// File: rtl/tiny86_trace_seq_if.sv
// Step stream handshake between a trace source (master) and the trace sequencer (slave).
interface tiny86_trace_seq_if #(
  parameter int STEP_W = 560
);
  logic              step_valid;
  logic              step_ready;
  logic [STEP_W-1:0] step;
  logic              step_last;

  modport master (
    output step_valid,
    output step,
    output step_last,
    input  step_ready
  );

  modport slave (
    input  step_valid,
    input  step,
    input  step_last,
    output step_ready
  );
endinterface

// File: rtl/tiny86_trace_seq.sv
// Trace driver/checker around the single-step tiny86 core: feeds steps to the core and
// verifies each step's register file against the core result of the step before it.
module tiny86_trace_seq #(
  parameter  int NUM_HINTS = 2,
  parameter  int MAX_STEPS = 1024,
  localparam int STEP_W    = 416 + 72 * NUM_HINTS,
  localparam int CNT_W     = $clog2(MAX_STEPS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  tiny86_trace_seq_if.slave     step_if,
  output logic [STEP_W-1:0]     cur_step_o,
  input  logic [319:0]          core_regs_i,
  input  logic                  core_fault_i,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [1:0]            err_code_o,
  output logic [CNT_W-1:0]      step_count_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam logic [1:0]       ERR_NONE  = 2'd0;
  localparam logic [1:0]       ERR_REGS  = 2'd1;
  localparam logic [1:0]       ERR_OVF   = 2'd2;
  localparam logic [1:0]       ERR_FAULT = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   cur_step_q, cur_step_d;
  logic [CNT_W-1:0]    step_count_q, step_count_d;
  logic                pass_q, pass_d;
  logic [1:0]          err_code_q, err_code_d;

  logic                ready;
  logic                accept;
  logic [319:0]        step_regs;
  logic                regs_mismatch;

  // Ready depends on state alone so upstream never sees a loop through step_valid.
  assign ready         = (state_q == IDLE) || (state_q == RUN);
  assign accept        = step_if.step_valid && ready;
  assign step_regs     = step_if.step[STEP_W-97 -: 320];
  assign regs_mismatch = (step_regs != core_regs_i);

  assign step_if.step_ready = ready;
  assign cur_step_o         = cur_step_q;
  assign step_count_o       = step_count_q;
  assign pass_o             = pass_q;
  assign err_code_o         = err_code_q;
  assign done_o             = (state_q == DONE);

  always_comb begin
    state_d      = state_q;
    cur_step_d   = cur_step_q;
    step_count_d = step_count_q;
    pass_d       = pass_q;
    err_code_d   = err_code_q;

    unique case (state_q)
      IDLE: begin
        // First step has no predecessor, so nothing to compare it against.
        if (accept) begin
          cur_step_d   = step_if.step;
          step_count_d = CNT_ONE;
          state_d      = step_if.step_last ? DRAIN : RUN;
        end
      end

      RUN: begin
        // A fault on the held step outranks a mismatch, which outranks overflow.
        if (accept) begin
          if (core_fault_i) begin
            err_code_d = ERR_FAULT;
            state_d    = DONE;
          end else if (regs_mismatch) begin
            err_code_d   = ERR_REGS;
            step_count_d = step_count_q + CNT_ONE;
            state_d      = DONE;
          end else if (step_count_q == CNT_MAX) begin
            err_code_d = ERR_OVF;
            state_d    = DONE;
          end else begin
            cur_step_d   = step_if.step;
            step_count_d = step_count_q + CNT_ONE;
            state_d      = step_if.step_last ? DRAIN : RUN;
          end
        end
      end

      DRAIN: begin
        // The final step has no successor to check, only the core's fault flag.
        if (core_fault_i) begin
          err_code_d = ERR_FAULT;
          pass_d     = 1'b0;
        end else begin
          pass_d = 1'b1;
        end
        state_d = DONE;
      end

      DONE: begin
        state_d = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_step_q   <= '0;
      step_count_q <= '0;
      pass_q       <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      cur_step_q   <= cur_step_d;
      step_count_q <= step_count_d;
      pass_q       <= pass_d;
      err_code_q   <= err_code_d;
    end
  end

endmodule
